ulap_loader: RTL and testbench

Bus-master sequencer that uploads a complete ULA+ palette and mode setting into the video block over the CPU I/O bus. It drives the same port protocol the CPU uses: register-select writes to 0xBF3B and data writes to 0xFF3B. It sits beside the Z80 in the core top level, is fed by the OSD/ioctl path, and takes the bus through a request/acknowledge handshake. Palette contents can therefore be restored, for example after a snapshot load, without running CPU code.

---
 rtl/ulap_loader_if.sv | 12 +
 rtl/ulap_loader.sv | 92 +++++++++
 tb/tb_ulap_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulap_loader_if.sv
// ulap_loader_if: CPU-style I/O bus plus request/ack handshake between the loader (master) and the CPU arbiter/bus (slave)
interface ulap_loader_if;
  logic        bus_req;
  logic        bus_ack;
  logic        bus_oe;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        nIORQ;
  logic        nWR;
  modport master (output bus_req, bus_oe, addr, dout, nIORQ, nWR, input bus_ack);
  modport slave (input bus_req, bus_oe, addr, dout, nIORQ, nWR, output bus_ack);
endinterface

// File: rtl/ulap_loader.sv
// ulap_loader: buffers a 64-entry ULA+ palette + 2-bit mode (ld_*) and on start replays it as 130 I/O writes over bus (ulap_loader_if.master); busy/done report progress
module ulap_loader #(
  parameter int T_SETUP = 2,
  parameter int T_ACT   = 4,
  parameter int T_HOLD  = 2
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ld_wr,
  input  logic [6:0]   ld_addr,
  input  logic [7:0]   ld_data,
  input  logic         start,
  input  logic [5:0]   tmx_cfg,
  output logic         busy,
  output logic         done,
  ulap_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, SETUP, ACT, HOLD, NEXT} state_t;
  state_t      st_q, st_d;
  logic [15:0] cnt_q, cnt_d, lim, addr_q, addr_d;
  logic [7:0]  idx_q, idx_d, dout_q, dout_d, wr_dout;
  logic [1:0]  mode_q, mode_d;
  logic        busy_q, busy_d, done_q, done_d, oe_q, oe_d, strb_q, strb_d;
  logic        on_bus, fresh, last;
  logic [7:0]  pal [64];
  always_ff @(posedge clk_sys)
    if (ld_wr && !busy_q && !ld_addr[6]) pal[ld_addr[5:0]] <= ld_data;
  always_comb begin
    st_d = st_q;
    cnt_d = '0;
    idx_d = idx_q;
    lim = 16'(st_q == SETUP ? T_SETUP : st_q == ACT ? T_ACT : T_HOLD);
    last = cnt_q == lim - 16'd1;
    case (st_q)
      IDLE: st_d = start ? REQ : IDLE;
      REQ: st_d = bus.bus_ack ? SETUP : REQ;
      SETUP, ACT, HOLD: begin
        st_d = !bus.bus_ack ? REQ : !last ? st_q : st_q == SETUP ? ACT : st_q == ACT ? HOLD : NEXT;
        cnt_d = (bus.bus_ack && !last) ? cnt_q + 16'd1 : '0;
      end
      default: begin
        st_d = idx_q == 8'd129 ? IDLE : SETUP;
        idx_d = idx_q == 8'd129 ? '0 : idx_q + 8'd1;
      end
    endcase
    on_bus = st_d inside {SETUP, ACT, HOLD};
    // addr/dout are latched once on entry to SETUP so they stay frozen until HOLD ends, even if tmx_cfg moves
    fresh = st_d == SETUP && st_q != SETUP;
    wr_dout = idx_d[7] ? (idx_d[0] ? {6'b0, mode_q} : {2'b01, tmx_cfg})
                       : (idx_d[0] ? pal[idx_d[6:1]] : {2'b00, idx_d[6:1]});
    addr_d = !on_bus ? 16'hFFFF : fresh ? (idx_d[0] ? 16'hFF3B : 16'hBF3B) : addr_q;
    dout_d = !on_bus ? 8'hFF : fresh ? wr_dout : dout_q;
    strb_d = st_d == ACT;
    oe_d = on_bus;
    busy_d = st_d != IDLE;
    done_d = st_q == NEXT && idx_q == 8'd129;
    mode_d = (ld_wr && !busy_q && ld_addr[6]) ? ld_data[1:0] : mode_q;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      mode_q <= '0;
      addr_q <= 16'hFFFF;
      dout_q <= 8'hFF;
      strb_q <= 1'b0;
      oe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      strb_q <= strb_d;
      oe_q <= oe_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.bus_req = busy_q;
  assign bus.bus_oe = oe_q;
  assign bus.addr = addr_q;
  assign bus.dout = dout_q;
  assign bus.nIORQ = !strb_q;
  assign bus.nWR = !strb_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_ulap_loader.sv
// tb_ulap_loader: directed bench for ulap_loader with a bus monitor and video palette model
module tb_ulap_loader;
  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ld_wr = 1'b0;
  logic [6:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic [5:0] tmx_cfg = 6'b000110;
  logic       busy, done, busy1, done1;
  int n_cmp = 0;
  int n_err = 0;

  ulap_loader_if bif ();
  ulap_loader_if bif1 ();

  ulap_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .tmx_cfg(tmx_cfg), .busy(busy), .done(done), .bus(bif)
  );

  ulap_loader #(.T_SETUP(1), .T_ACT(1), .T_HOLD(1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start1), .tmx_cfg(tmx_cfg), .busy(busy1), .done(done1), .bus(bif1)
  );

  always #5 clk_sys = ~clk_sys;

  logic [23:0] mon [$];
  logic [7:0]  vpal [64];
  logic [7:0]  vsel = 8'h00;
  logic        v_ena = 1'b0, v_mono = 1'b0, prev0 = 1'b1, prev1 = 1'b1;
  int bad_same = 0;
  int s1_cnt = 0, s1_badlow = 0, s1_badhigh = 0, low1 = 0, high1 = 0;

  initial begin
    forever begin
      @(negedge clk_sys);
      if (bif.nIORQ !== bif.nWR || bif1.nIORQ !== bif1.nWR) bad_same++;
      if (prev0 && !bif.nIORQ) begin
        mon.push_back({bif.addr, bif.dout});
        if (bif.addr == 16'hBF3B) vsel = bif.dout;
        else if (vsel[7:6] == 2'b00) vpal[vsel[5:0]] = bif.dout;
        else if (vsel[7:6] == 2'b01) {v_mono, v_ena} = bif.dout[1:0];
      end
      prev0 = bif.nIORQ;
      if (!bif1.nIORQ) begin
        if (prev1) begin
          if (s1_cnt > 0 && high1 < 3) s1_badhigh++;
          s1_cnt++;
        end
        low1++;
      end else begin
        if (!prev1) begin
          if (low1 != 1) s1_badlow++;
          low1 = 0;
          high1 = 0;
        end
        high1++;
      end
      prev1 = bif1.nIORQ;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] exp_wr(int k);
    logic [7:0] e = 8'(k / 2);
    if (k == 128) return {16'hBF3B, 8'h46};
    if (k == 129) return {16'hFF3B, 8'h01};
    return (k % 2 != 0) ? {16'hFF3B, e ^ 8'hA5} : {16'hBF3B, e};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] d);
    ld_addr = 7'(i);
    ld_data = d;
    ld_wr = 1'b1;
    tick();
    ld_wr = 1'b0;
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    while (n < 3000 && done !== 1'b1) begin
      @(negedge clk_sys);
      n++;
    end
  endtask

  task automatic wait_oe(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if ((which ? bif1.bus_oe : bif.bus_oe) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [29:0] got;
    reset = 1'b1;
    bif.bus_ack = 1'b0;
    bif1.bus_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk_sys);
    got = {bif.bus_req, bif.bus_oe, bif.addr, bif.dout, bif.nIORQ, bif.nWR, busy, done};
    n_cmp++;
    if (got !== {2'b00, 16'hFFFF, 8'hFF, 2'b11, 2'b00}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", got, {2'b00, 16'hFFFF, 8'hFF, 2'b11, 2'b00});
    end
  endtask

  task automatic test_upload();
    int n, bad;
    bit ok;
    for (int i = 0; i < 64; i++) load(i, 8'(i) ^ 8'hA5);
    load(64, 8'h01);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk_sys);
    n_cmp++;
    if ({busy, bif.bus_req, bif.bus_oe} !== 3'b110) begin
      n_err++;
      $display("FAIL start_latency: got %b want 110", {busy, bif.bus_req, bif.bus_oe});
    end
    mon.delete();
    start = 1'b1;
    ld_addr = 7'd5;
    ld_data = 8'h00;
    ld_wr = 1'b1;
    tick();
    start = 1'b0;
    ld_wr = 1'b0;
    bif.bus_ack = 1'b1;
    wait_oe(1'b0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL upload_oe: got %b want 1", ok);
    end
    wait_done0(n);
    n_cmp++;
    if (n != 1170) begin
      n_err++;
      $display("FAIL upload_cycles: got %0d want 1170", n);
    end
    n_cmp++;
    if ({busy, bif.bus_req, bif.bus_oe} !== 3'b000) begin
      n_err++;
      $display("FAIL done_release: got %b want 000", {busy, bif.bus_req, bif.bus_oe});
    end
    @(negedge clk_sys);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got %b want 0", done);
    end
    n_cmp++;
    if (mon.size() != 130) begin
      n_err++;
      $display("FAIL upload_count: got %0d want 130", mon.size());
    end
    bad = 0;
    for (int k = 0; k < 130; k++) if (k >= mon.size() || mon[k] !== exp_wr(k)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL upload_order: got %0d bad writes want 0", bad);
    end
    n_cmp++;
    if (mon.size() < 129 || mon[128] !== 24'hBF3B46) begin
      n_err++;
      $display("FAIL group_select: got %h want bf3b46", mon.size() > 128 ? mon[128] : 24'h0);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (vpal[i] !== (8'(i) ^ 8'hA5)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL video_palette: got %0d bad entries want 0", bad);
    end
    n_cmp++;
    if ({v_mono, v_ena} !== 2'b01) begin
      n_err++;
      $display("FAIL video_mode: got %b want 01", {v_mono, v_ena});
    end
    n_cmp++;
    if (vpal[5] !== 8'hA0) begin
      n_err++;
      $display("FAIL busy_write_dropped: got %h want a0", vpal[5]);
    end
    repeat (5) @(negedge clk_sys);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_ignored: got %b want 0", busy);
    end
    bif.bus_ack = 1'b0;
  endtask

  task automatic test_bus_loss();
    int n, bad;
    bit ok;
    mon.delete();
    bif.bus_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (mon.size() == 38) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL loss_reach_w37: got %0d writes want 38", mon.size());
    end
    tick();
    bif.bus_ack = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    n_cmp++;
    if ({bif.nIORQ, bif.nWR, bif.bus_oe, bif.bus_req} !== 4'b1101) begin
      n_err++;
      $display("FAIL loss_release: got %b want 1101", {bif.nIORQ, bif.nWR, bif.bus_oe, bif.bus_req});
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (bif.bus_oe !== 1'b0 || bif.nIORQ !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL loss_idle: got %0d driven cycles want 0", bad);
    end
    bif.bus_ack = 1'b1;
    wait_done0(n);
    n_cmp++;
    if (n >= 3000) begin
      n_err++;
      $display("FAIL loss_done: got timeout want done");
    end
    n_cmp++;
    if (mon.size() != 131) begin
      n_err++;
      $display("FAIL loss_count: got %0d want 131", mon.size());
    end
    bad = 0;
    for (int k = 0; k < 131; k++) if (k >= mon.size() || mon[k] !== exp_wr(k < 38 ? k : k - 1)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL loss_reissue: got %0d bad writes want 0", bad);
    end
    bif.bus_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, bad;
    bit ok, gap;
    logic [29:0] got;
    mon.delete();
    bif.bus_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    gap = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (mon.size() >= 80 && gap && bif.bus_oe === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (mon.size() >= 80 && bif.bus_oe === 1'b0) gap = 1'b1;
    end
    n_cmp++;
    if ({ok, bif.addr, bif.dout, bif.nIORQ} !== {1'b1, 16'hBF3B, 8'h28, 1'b1}) begin
      n_err++;
      $display("FAIL setup_w80: got %h want 1bf3b281", {ok, bif.addr, bif.dout, bif.nIORQ});
    end
    reset = 1'b1;
    @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    got = {bif.bus_req, bif.bus_oe, bif.addr, bif.dout, bif.nIORQ, bif.nWR, busy, done};
    n_cmp++;
    if (got !== {2'b00, 16'hFFFF, 8'hFF, 2'b11, 2'b00}) begin
      n_err++;
      $display("FAIL midreset_state: got %h want %h", got, {2'b00, 16'hFFFF, 8'hFF, 2'b11, 2'b00});
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk_sys);
      if (bif.nIORQ !== 1'b1 || bif.bus_oe !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || mon.size() != 80) begin
      n_err++;
      $display("FAIL midreset_quiet: got %0d busy cycles %0d writes want 0 and 80", bad, mon.size());
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done0(n);
    n_cmp++;
    if (n >= 3000 || mon.size() != 210) begin
      n_err++;
      $display("FAIL restart_count: got %0d writes want 210", mon.size());
    end
    n_cmp++;
    if (mon.size() < 210 || {mon[80], mon[81], mon[209]} !== {exp_wr(0), exp_wr(1), 24'hFF3B00}) begin
      n_err++;
      $display("FAIL restart_data: got %0d writes want first bf3b00 ff3ba5 last ff3b00", mon.size());
    end
    bif.bus_ack = 1'b0;
  endtask

  task automatic test_strobe_spacing();
    int n;
    bit ok;
    bif1.bus_ack = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_oe(1'b1, ok);
    n = 0;
    while (n < 3000 && done1 !== 1'b1) begin
      @(negedge clk_sys);
      n++;
    end
    n_cmp++;
    if (ok !== 1'b1 || n != 520) begin
      n_err++;
      $display("FAIL fast_cycles: got %0d want 520", n);
    end
    n_cmp++;
    if (s1_cnt != 130) begin
      n_err++;
      $display("FAIL fast_count: got %0d want 130", s1_cnt);
    end
    n_cmp++;
    if (s1_badlow != 0 || s1_badhigh != 0) begin
      n_err++;
      $display("FAIL fast_spacing: got %0d low %0d high violations want 0", s1_badlow, s1_badhigh);
    end
    n_cmp++;
    if (bad_same != 0) begin
      n_err++;
      $display("FAIL iorq_wr_align: got %0d split cycles want 0", bad_same);
    end
    bif1.bus_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_upload();
    test_bus_loss();
    test_reset_mid();
    test_strobe_spacing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
